// File: rtl/jtag_ir_pkg.sv
// JTAG instruction register: shared instruction types, opcodes
// and SELECT_BSR validity helper.
package jtag_ir_pkg;

   typedef enum logic [2:0] {
      BYPASS,
      EXTEST,
      INTEST,
      SAMPLE,
      IDCODE,
      SELECT_BSR,
      BAD
   } instr_type_e;

   function automatic logic [31:0] op_bypass(int w);
      return ~(32'hFFFF_FFFF << w);
   endfunction

   function automatic logic [31:0] op_extest(int w);
      return 32'd0 & op_bypass(w);
   endfunction

   function automatic logic [31:0] op_intest(int w);
      return 32'd1 & op_bypass(w);
   endfunction

   function automatic logic [31:0] op_sample(int w);
      return 32'd2 & op_bypass(w);
   endfunction

   function automatic logic [31:0] op_idcode(int w);
      return 32'd4 & op_bypass(w);
   endfunction

   // MSB clear, low bits 11, chain field in range
   function automatic logic is_select_bsr(logic [31:0] code,
                                          int num_chains,
                                          int w);
      logic [31:0] chain;
      logic [31:0] msb;
      chain = (code >> 2) & op_bypass(w - 3);
      msb   = (code >> (w - 1)) & 32'd1;
      return (code[1:0] == 2'b11) && (msb == 32'd0) &&
             (chain < 32'(num_chains));
   endfunction

endpackage

// File: rtl/jtag_ir_decoder.sv
// Combinational instruction decode: code -> type and chain field.
// BAD covers out-of-range chains and unsupported IDCODE.
module jtag_ir_decoder
   import jtag_ir_pkg::*;
#(
   parameter int INSTR_W    = 5,
   parameter int NUM_CHAINS = 3,
   parameter int HAS_IDCODE = 1,
   parameter int SEL_W      = INSTR_W - 3
) (
   input  logic [INSTR_W-1:0] code,
   output instr_type_e        itype,
   output logic [SEL_W-1:0]   chain
);

   localparam logic [INSTR_W-1:0] OP_BYP = INSTR_W'(op_bypass(INSTR_W));
   localparam logic [INSTR_W-1:0] OP_EXT = INSTR_W'(op_extest(INSTR_W));
   localparam logic [INSTR_W-1:0] OP_INT = INSTR_W'(op_intest(INSTR_W));
   localparam logic [INSTR_W-1:0] OP_SMP = INSTR_W'(op_sample(INSTR_W));
   localparam logic [INSTR_W-1:0] OP_IDC = INSTR_W'(op_idcode(INSTR_W));

   logic bsr_ok;

   assign chain  = code[INSTR_W-2:2];
   assign bsr_ok = is_select_bsr(32'(code), NUM_CHAINS, INSTR_W);

   always_comb begin
      itype = BAD;
      unique case (1'b1)
         code == OP_BYP: itype = BYPASS;
         code == OP_EXT: itype = EXTEST;
         code == OP_INT: itype = INTEST;
         code == OP_SMP: itype = SAMPLE;
         code == OP_IDC: itype = (HAS_IDCODE != 0) ? IDCODE : BAD;
         bsr_ok:         itype = SELECT_BSR;
         default:        itype = BAD;
      endcase
   end

endmodule

// File: rtl/jtag_ir.sv
// JTAG instruction register: capture/shift/update stage, active
// instruction, retained chain select and sticky bad flag.
module jtag_ir
   import jtag_ir_pkg::*;
#(
   parameter int INSTR_W    = 5,
   parameter int NUM_CHAINS = 3,
   parameter int SEL_W      = INSTR_W - 3,
   parameter int HAS_IDCODE = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               test_logic_reset,
   input  logic               capture_ir,
   input  logic               shift_ir,
   input  logic               update_ir,
   input  logic               tdi,
   output logic               ir_tdo,
   output logic [INSTR_W-1:0] active_ir,
   output logic [SEL_W-1:0]   mux_sel,
   output logic               bypass_sel,
   output logic               idcode_sel,
   output logic               sample_preload,
   output logic               extest,
   output logic               intest,
   output logic               ex_in_test,
   output logic               bad_instr
);

   localparam logic [INSTR_W-1:0] RST_IR = (HAS_IDCODE != 0) ?
      INSTR_W'(op_idcode(INSTR_W)) : INSTR_W'(op_bypass(INSTR_W));

   logic [INSTR_W-1:0] shift_reg;
   logic [INSTR_W-1:0] cap_val;
   logic [SEL_W-1:0]   hold_sel;
   instr_type_e        act_type;
   instr_type_e        sr_type;
   logic [SEL_W-1:0]   act_chain;
   logic [SEL_W-1:0]   sr_chain;

   jtag_ir_decoder #(
      .INSTR_W    (INSTR_W),
      .NUM_CHAINS (NUM_CHAINS),
      .HAS_IDCODE (HAS_IDCODE),
      .SEL_W      (SEL_W)
   ) u_dec_act (
      .code  (active_ir),
      .itype (act_type),
      .chain (act_chain)
   );

   jtag_ir_decoder #(
      .INSTR_W    (INSTR_W),
      .NUM_CHAINS (NUM_CHAINS),
      .HAS_IDCODE (HAS_IDCODE),
      .SEL_W      (SEL_W)
   ) u_dec_sr (
      .code  (shift_reg),
      .itype (sr_type),
      .chain (sr_chain)
   );

   // Capture pattern: ...0 bad 0 1
   always_comb begin
      cap_val    = '0;
      cap_val[0] = 1'b1;
      cap_val[2] = bad_instr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_ir <= RST_IR;
         shift_reg <= INSTR_W'(1);
         hold_sel  <= '0;
         bad_instr <= 1'b0;
      end else if (test_logic_reset) begin
         active_ir <= RST_IR;
         shift_reg <= INSTR_W'(1);
         hold_sel  <= '0;
      end else if (update_ir) begin
         active_ir <= shift_reg;
         if (sr_type == SELECT_BSR) hold_sel <= sr_chain;
         if (sr_type == BAD) bad_instr <= 1'b1;
      end else if (capture_ir) begin
         shift_reg <= cap_val;
      end else if (shift_ir) begin
         shift_reg <= {tdi, shift_reg[INSTR_W-1:1]};
      end
   end

   assign ir_tdo         = shift_reg[0];
   assign mux_sel        = (act_type == SELECT_BSR) ? act_chain : hold_sel;
   assign bypass_sel     = (act_type == BYPASS) || (act_type == BAD);
   assign idcode_sel     = (act_type == IDCODE);
   assign sample_preload = (act_type == SAMPLE);
   assign extest         = (act_type == EXTEST);
   assign intest         = (act_type == INTEST);
   assign ex_in_test     = extest | intest;

endmodule

// File: tb/tb_jtag_ir.sv
// Bench for jtag_ir: directed plan then random strobes, both
// HAS_IDCODE builds, checked against an arithmetic model.
module tb_jtag_ir;

   localparam int W  = 5;
   localparam int NC = 3;
   localparam int SW = W - 3;

   logic clk = 1'b0;
   logic reset = 1'b0, tlr = 1'b0, cap = 1'b0;
   logic sh = 1'b0, upd = 1'b0, tdi = 1'b0;

   logic          a_tdo, a_byp, a_idc, a_smp, a_ext, a_int, a_exin, a_bad;
   logic [W-1:0]  a_act;
   logic [SW-1:0] a_mux;
   logic          b_tdo, b_byp, b_idc, b_smp, b_ext, b_int, b_exin, b_bad;
   logic [W-1:0]  b_act;
   logic [SW-1:0] b_mux;

   int n_cmp = 0;
   int n_bad = 0;

   int m_sr[2], m_act[2], m_hold[2];
   bit m_bad[2];

   always #5 clk = ~clk;

   jtag_ir #(.INSTR_W(W), .NUM_CHAINS(NC), .HAS_IDCODE(1)) dut_a (
      .clk(clk), .reset(reset), .test_logic_reset(tlr),
      .capture_ir(cap), .shift_ir(sh), .update_ir(upd), .tdi(tdi),
      .ir_tdo(a_tdo), .active_ir(a_act), .mux_sel(a_mux),
      .bypass_sel(a_byp), .idcode_sel(a_idc), .sample_preload(a_smp),
      .extest(a_ext), .intest(a_int), .ex_in_test(a_exin),
      .bad_instr(a_bad)
   );

   jtag_ir #(.INSTR_W(W), .NUM_CHAINS(NC), .HAS_IDCODE(0)) dut_b (
      .clk(clk), .reset(reset), .test_logic_reset(tlr),
      .capture_ir(cap), .shift_ir(sh), .update_ir(upd), .tdi(tdi),
      .ir_tdo(b_tdo), .active_ir(b_act), .mux_sel(b_mux),
      .bypass_sel(b_byp), .idcode_sel(b_idc), .sample_preload(b_smp),
      .extest(b_ext), .intest(b_int), .ex_in_test(b_exin),
      .bad_instr(b_bad)
   );

   // 0 byp, 1 extest, 2 intest, 3 sample, 4 idcode, 5 bsr, 6 bad
   function automatic int kind(int code, bit has_id);
      int chain;
      chain = (code / 4) % (2 ** SW);
      if (code == 2 ** W - 1) return 0;
      if (code == 0) return 1;
      if (code == 1) return 2;
      if (code == 2) return 3;
      if (code == 4) return has_id ? 4 : 6;
      if (code < 2 ** (W - 1) && code % 4 == 3 && chain < NC) return 5;
      return 6;
   endfunction

   function automatic int chain_of(int code);
      return (code / 4) % (2 ** SW);
   endfunction

   task automatic cmp(string tag, int i, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s dut%0d: got %0h expected %0h", tag, i, obs, exp);
      end
   endtask

   task automatic model_edge(bit r, bit t, bit c, bit s, bit u, bit d);
      for (int i = 0; i < 2; i++) begin
         if (r || t) begin
            m_act[i]  = (i == 0) ? 4 : 2 ** W - 1;
            m_sr[i]   = 1;
            m_hold[i] = 0;
            if (r) m_bad[i] = 0;
         end else if (u) begin
            m_act[i] = m_sr[i];
            if (kind(m_sr[i], i == 0) == 5) m_hold[i] = chain_of(m_sr[i]);
            if (kind(m_sr[i], i == 0) == 6) m_bad[i] = 1;
         end else if (c) begin
            m_sr[i] = 1 + 4 * int'(m_bad[i]);
         end else if (s) begin
            m_sr[i] = m_sr[i] / 2 + int'(d) * 2 ** (W - 1);
         end
      end
   endtask

   task automatic chk(int i, logic tdo, logic [W-1:0] act,
                      logic [SW-1:0] mux, logic [5:0] fl, logic bad);
      int k;
      logic [5:0] ef;
      k = kind(m_act[i], i == 0);
      ef = {k == 0 || k == 6, k == 4, k == 3, k == 1, k == 2,
            k == 1 || k == 2};
      cmp("ir_tdo", i, 32'(tdo), 32'(m_sr[i] % 2));
      cmp("active_ir", i, 32'(act), 32'(m_act[i]));
      cmp("mux_sel", i, 32'(mux),
          32'((k == 5) ? chain_of(m_act[i]) : m_hold[i]));
      cmp("mode_flags", i, 32'(fl), 32'(ef));
      cmp("bad_instr", i, 32'(bad), 32'(m_bad[i]));
   endtask

   task automatic step(bit r, bit t, bit c, bit s, bit u, bit d);
      reset = r; tlr = t; cap = c; sh = s; upd = u; tdi = d;
      @(posedge clk);
      model_edge(r, t, c, s, u, d);
      #1;
      chk(0, a_tdo, a_act, a_mux,
          {a_byp, a_idc, a_smp, a_ext, a_int, a_exin}, a_bad);
      chk(1, b_tdo, b_act, b_mux,
          {b_byp, b_idc, b_smp, b_ext, b_int, b_exin}, b_bad);
   endtask

   task automatic load(int code);
      step(0, 0, 1, 0, 0, 0);
      for (int b = 0; b < W; b++) step(0, 0, 0, 1, 0, ((code >> b) & 1) != 0);
      step(0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      int r;
      // reset state and capture pattern
      step(1, 0, 0, 0, 0, 0);
      cmp("rst_act", 0, 32'(a_act), 32'b00100);
      cmp("rst_idc", 0, 32'(a_idc), 32'd1);
      cmp("rst_byp_noid", 1, 32'(b_byp), 32'd1);
      step(0, 0, 1, 0, 0, 0);
      for (int b = 0; b < W; b++) step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      // EXTEST then INTEST
      load(0);
      cmp("extest", 0, 32'({a_ext, a_exin}), 32'b11);
      load(1);
      cmp("intest", 0, 32'({a_int, a_ext}), 32'b10);
      // chain 2 retained across SAMPLE
      load(5'b01011);
      cmp("bsr2", 0, 32'(a_mux), 32'd2);
      load(5'b00010);
      cmp("smp_keep", 0, 32'({a_smp, a_mux}), 32'b110);
      // out-of-range chain is BAD
      load(5'b01111);
      cmp("bad_chain", 0, 32'({a_byp, a_bad, a_mux}), 32'b1110);
      step(0, 0, 1, 0, 0, 0);
      for (int b = 0; b < W; b++) step(0, 0, 0, 1, 0, 1);
      // TLR mid-shift, bad kept; then reset clears it
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 1);
      step(0, 1, 0, 0, 0, 0);
      cmp("tlr_bad", 0, 32'({a_act, a_bad}), 32'b001001);
      step(1, 0, 0, 0, 0, 0);
      cmp("rst_bad", 0, 32'(a_bad), 32'd0);
      // update+shift together: update wins
      step(0, 0, 1, 0, 0, 0);
      for (int b = 0; b < W; b++) step(0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 1, 1, 0);
      cmp("upd_prio", 0, 32'({a_act, a_tdo}), 32'b111111);
      // IDCODE on the build without it
      load(5'b00100);
      cmp("noid_bad", 1, 32'({b_bad, b_byp, b_idc}), 32'b110);
      step(1, 0, 0, 0, 0, 0);
      cmp("noid_rst", 1, 32'({b_byp, b_act}), 32'b111111);
      // random strobes
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2)       step(1, 0, 0, 0, 0, 0);
         else if (r < 5)  step(0, 1, 0, $urandom_range(0, 1) != 0, 0, 0);
         else if (r < 15) step(0, 0, 0, 0, 1, 0);
         else if (r < 25) step(0, 0, 1, 0, 0, 0);
         else if (r < 90) step(0, 0, 0, 1, 0, $urandom_range(0, 1) != 0);
         else if (r < 95) step(0, 0, 0, 0, 0, 0);
         else             step(0, 0, 1, 1, $urandom_range(0, 1) != 0,
                               $urandom_range(0, 1) != 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
